reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer that terminates the ALU result interface. Issue allocates an entry per instruction and receives its unit tag. The ALU returns results via `o_ROB_cnt`/`newpc`/`result`/`rd`/`excp`. This block marks entries done, broadcasts `(u, udata)` back to the ALU and issue for operand wakeup, and retires entries strictly in program order to the register file and PC. It handles redirects and exceptions at retirement.

## Interface
- DEPTH, 8 — entries; power of two, 2..16.
- PTR_W, 3 — log2(DEPTH).
- clk  in  1  — system clock; all state updates on rising edge.
- rst  in  1  — synchronous, active-high reset.
- i_IDSUE_alloc  in  1  — allocate one entry this cycle.
- i_IDSUE_cnt  in  `CntBus` — unique instruction tag of the allocated instruction.
- i_IDSUE_pc  in  `AddrBus` — PC of the allocated instruction.
- o_IDSUE_u  out  `UnitBus` — unit tag for the next allocation, equal to tail index + 1.
- o_IDSUE_full  out  1  — no free entry; allocation is refused.
- i_ALU_cnt  in  `CntBus` — completion tag.
- i_ALU_newpc  in  `AddrBus` — resolved next PC.
- i_ALU_result  in  `DataBus` — result value.
- i_ALU_rd  in  `RegBus` — destination register; `RegZero` means no write.
- i_ALU_excp  in  `ExcpBus` — exception code; 0 means none.
- o_ROB_u  out  `UnitBus` — broadcast unit tag; `NoUnit` when idle.
- o_ROB_udata  out  `DataBus` — broadcast value.
- o_REG_we  out  1  — register write strobe.
- o_REG_rd  out  `RegBus` — register write address.
- o_REG_data  out  `DataBus` — register write data.
- o_PC_redirect  out  1  — fetch redirect strobe.
- o_PC_target  out  `AddrBus` — redirect target.
- o_excp_valid  out  1  — exception strobe.
- o_excp_code  out  `ExcpBus` — exception code.
- o_excp_pc  out  `AddrBus` — PC of the faulting instruction.

## Operation
- Circular buffer with head and tail pointers of PTR_W bits and a count of PTR_W+1 bits.
- Each entry holds: busy, done, cnt, pc, newpc, result, rd, excp.
- **Allocate:** when i_IDSUE_alloc=1 and not full, the tail entry is set to busy=1, done=0, cnt, pc. Tail increments mod DEPTH.
- **Complete:** an associative match of i_ALU_cnt against all entries with busy=1 and done=0.
  - On a hit, newpc, result, rd and excp are captured and done is set to 1.
  - No hit, or a match on an already-done entry (the ALU holds its outputs between tasks), is ignored.
  - At most one hit; tags are unique.
- **Broadcast:** each hit produces exactly one broadcast with u = hit index + 1 and udata = i_ALU_result. Otherwise `NoUnit` is driven and udata holds its last value.
- **Commit:** evaluated each cycle on the head entry when busy=1 and done=1.
  - Exception (excp≠0): o_excp_valid=1 with code and pc. No register write. Full flush.
  - Otherwise, if rd≠`RegZero`: o_REG_we=1 with rd and result.
  - If newpc ≠ pc+`PcWidth`: o_PC_redirect=1, o_PC_target=newpc, full flush after the write.
  - On a normal commit, the head entry's busy is cleared and head increments.
- **Flush:** clears all busy and done bits and sets head = tail = count = 0. Allocation and completion in the flush cycle are discarded.
- Commit rate: at most one entry per cycle. Allocation rate: at most one per cycle.

## Timing
- **Reset:**
  - All strobes are 0 and o_ROB_u=`NoUnit`.
  - o_ROB_udata, o_REG_rd, o_REG_data, o_PC_target, o_excp_code and o_excp_pc are 0.
  - o_IDSUE_full=0, o_IDSUE_u=1.
  - All entries are invalid.
  - Reset asserted mid-operation discards all entries and takes effect at the next edge.
- **Allocation:** an allocation at edge E is visible as busy after E. o_IDSUE_full and o_IDSUE_u are registered and update after E.
- **Full/empty boundaries:**
  - Alloc while full is dropped even if a commit occurs the same edge.
  - A completion and a commit of the same entry at one edge is impossible; done must be registered first.
  - Alloc and commit at the same edge leave count unchanged.
- **Commit outputs:** all commit strobes are registered, one-cycle pulses.
  - Completion captured at edge E, entry at head → strobes high for the cycle after E+1.
  - Completion-to-write latency is 2 cycles.
- **Wrap-around:** tail and head wrap from DEPTH-1 to 0. The unit tag wraps from DEPTH to 1.
- **Back-to-back commits:** consecutive done entries commit on consecutive cycles.

## Configuration
- **ROB_BYPASS_EN defined:** o_ROB_u and o_ROB_udata are driven combinationally from the completion match in the same cycle the ALU presents the result. The broadcast is valid before edge E.
- **ROB_BYPASS_EN undefined:** the broadcast is registered and appears in the cycle after edge E, for one cycle. No other behaviour differs.

## Test plan
- Reset, then alloc cnt=5, pc=0x100; ALU returns cnt=5, rd=3, result=0x2A, newpc=0x104 → u=1, udata=0x2A broadcast once; o_REG_we with rd=3, data=0x2A two cycles after completion; head advances.
- Allocate cnt=1,2,3; complete in order 3,1,2 → broadcasts in completion order (u=3,1,2); commits in program order 1,2,3 on consecutive cycles.
- Allocate 8 entries → o_IDSUE_full=1; a ninth alloc is dropped. Commit one, then allocate → the slot is reused with u=1 after wrap.
- Branch at pc=0x200 with rd=`RegZero`, newpc=0x180, one younger entry allocated → no register write; o_PC_redirect=1, target=0x180; buffer empty afterwards; a later ALU match on the younger cnt is ignored.
- Completion with excp=2 at pc=0x300 → o_excp_valid=1, code=2, o_excp_pc=0x300; no register write; flush.
- ALU holds cnt=7 stable for 4 cycles → exactly one broadcast and one commit. Run under both settings of ROB_BYPASS_EN; with it defined the broadcast is checked in the same cycle as the completion, without it one cycle later.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Issue/ALU/retire signal bundle for reorder_buffer; the slave modport is the buffer side.
interface reorder_buffer_if #(
    parameter int PTR_W = 3
);
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int EXCP_W = 4;
    localparam int UNIT_W = PTR_W + 1;

    logic              i_IDSUE_alloc;
    logic [CNT_W-1:0]  i_IDSUE_cnt;
    logic [ADDR_W-1:0] i_IDSUE_pc;
    logic [UNIT_W-1:0] o_IDSUE_u;
    logic              o_IDSUE_full;
    logic [CNT_W-1:0]  i_ALU_cnt;
    logic [ADDR_W-1:0] i_ALU_newpc;
    logic [DATA_W-1:0] i_ALU_result;
    logic [REG_W-1:0]  i_ALU_rd;
    logic [EXCP_W-1:0] i_ALU_excp;
    logic [UNIT_W-1:0] o_ROB_u;
    logic [DATA_W-1:0] o_ROB_udata;
    logic              o_REG_we;
    logic [REG_W-1:0]  o_REG_rd;
    logic [DATA_W-1:0] o_REG_data;
    logic              o_PC_redirect;
    logic [ADDR_W-1:0] o_PC_target;
    logic              o_excp_valid;
    logic [EXCP_W-1:0] o_excp_code;
    logic [ADDR_W-1:0] o_excp_pc;

    modport slave (
        input  i_IDSUE_alloc, i_IDSUE_cnt, i_IDSUE_pc,
        input  i_ALU_cnt, i_ALU_newpc, i_ALU_result, i_ALU_rd, i_ALU_excp,
        output o_IDSUE_u, o_IDSUE_full, o_ROB_u, o_ROB_udata,
        output o_REG_we, o_REG_rd, o_REG_data, o_PC_redirect, o_PC_target,
        output o_excp_valid, o_excp_code, o_excp_pc
    );

    modport master (
        output i_IDSUE_alloc, i_IDSUE_cnt, i_IDSUE_pc,
        output i_ALU_cnt, i_ALU_newpc, i_ALU_result, i_ALU_rd, i_ALU_excp,
        input  o_IDSUE_u, o_IDSUE_full, o_ROB_u, o_ROB_udata,
        input  o_REG_we, o_REG_rd, o_REG_data, o_PC_redirect, o_PC_target,
        input  o_excp_valid, o_excp_code, o_excp_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tag-matched completion, unit broadcast, in-order commit with flush.
// Optional ROB_BYPASS_EN drives the broadcast combinationally from the completion match.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave rob
);
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int EXCP_W = 4;
    localparam int UNIT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    logic [DEPTH-1:0]  busy_r, done_r;
    logic [CNT_W-1:0]  cnt_r    [DEPTH];
    logic [ADDR_W-1:0] pc_r     [DEPTH];
    logic [ADDR_W-1:0] newpc_r  [DEPTH];
    logic [DATA_W-1:0] result_r [DEPTH];
    logic [REG_W-1:0]  rd_r     [DEPTH];
    logic [EXCP_W-1:0] excp_r   [DEPTH];

    logic [PTR_W-1:0]  head_r, tail_r;
    logic [PTR_W:0]    count_r;
    logic              full_r;
    logic [UNIT_W-1:0] unit_r;

    logic [DEPTH-1:0]  hit_vec_s;
    logic              hit_s, cap_s;
    logic [PTR_W-1:0]  hit_idx_s;
    logic              commit_s, excp_s, redirect_s, write_s, flush_s, retire_s, alloc_ok_s;
    logic [PTR_W-1:0]  head_next_s, tail_next_s;
    logic [PTR_W:0]    count_next_s;

    logic              reg_we_r, redirect_r, excp_valid_r;
    logic [REG_W-1:0]  reg_rd_r;
    logic [DATA_W-1:0] reg_data_r, udata_r;
    logic [ADDR_W-1:0] target_r, excp_pc_r;
    logic [EXCP_W-1:0] excp_code_r;

    // Associative match of the ALU tag against in-flight, not-yet-done entries
    always_comb begin
        hit_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec_s[i] = busy_r[i] && !done_r[i] && (cnt_r[i] == rob.i_ALU_cnt);
            hit_idx_s    = hit_vec_s[i] ? PTR_W'(i) : hit_idx_s;
        end
        hit_s = |hit_vec_s;
    end

    // Head commit decode and pointer/count next-state; a flush discards same-cycle alloc and completion
    always_comb begin
        commit_s     = busy_r[head_r] && done_r[head_r];
        excp_s       = commit_s && (excp_r[head_r] != '0);
        write_s      = commit_s && !excp_s && (rd_r[head_r] != '0);
        redirect_s   = commit_s && !excp_s && (newpc_r[head_r] != (pc_r[head_r] + PC_STEP));
        flush_s      = excp_s || redirect_s;
        retire_s     = commit_s && !flush_s;
        cap_s        = hit_s && !flush_s;
        alloc_ok_s   = rob.i_IDSUE_alloc && !full_r && !flush_s;
        head_next_s  = flush_s ? '0 : head_r + PTR_W'(retire_s);
        tail_next_s  = flush_s ? '0 : tail_r + PTR_W'(alloc_ok_s);
        count_next_s = flush_s ? '0 : count_r + (PTR_W+1)'(alloc_ok_s) - (PTR_W+1)'(retire_s);
    end

    // Pointers, occupancy and per-entry valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= '0;
            done_r  <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            unit_r  <= UNIT_W'(1);
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
            full_r  <= (count_next_s == (PTR_W+1)'(DEPTH));
            unit_r  <= {1'b0, tail_next_s} + UNIT_W'(1);
            if (flush_s) begin
                busy_r <= '0;
                done_r <= '0;
            end else begin
                if (retire_s) begin
                    busy_r[head_r] <= 1'b0;
                    done_r[head_r] <= 1'b0;
                end
                if (alloc_ok_s) begin
                    busy_r[tail_r] <= 1'b1;
                    done_r[tail_r] <= 1'b0;
                end
                if (cap_s) begin
                    done_r[hit_idx_s] <= 1'b1;
                end
            end
        end
    end

    // Entry payload; qualified by the valid bits so it needs no reset
    always_ff @(posedge clk) begin
        if (alloc_ok_s) begin
            cnt_r[tail_r] <= rob.i_IDSUE_cnt;
            pc_r[tail_r]  <= rob.i_IDSUE_pc;
        end
        if (cap_s) begin
            newpc_r[hit_idx_s]  <= rob.i_ALU_newpc;
            result_r[hit_idx_s] <= rob.i_ALU_result;
            rd_r[hit_idx_s]     <= rob.i_ALU_rd;
            excp_r[hit_idx_s]   <= rob.i_ALU_excp;
        end
    end

    // Registered commit strobes; data fields hold their last value between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we_r     <= 1'b0;
            reg_rd_r     <= '0;
            reg_data_r   <= '0;
            redirect_r   <= 1'b0;
            target_r     <= '0;
            excp_valid_r <= 1'b0;
            excp_code_r  <= '0;
            excp_pc_r    <= '0;
        end else begin
            reg_we_r     <= write_s;
            redirect_r   <= redirect_s;
            excp_valid_r <= excp_s;
            if (write_s) begin
                reg_rd_r   <= rd_r[head_r];
                reg_data_r <= result_r[head_r];
            end
            if (redirect_s) begin
                target_r <= newpc_r[head_r];
            end
            if (excp_s) begin
                excp_code_r <= excp_r[head_r];
                excp_pc_r   <= pc_r[head_r];
            end
        end
    end

`ifdef ROB_BYPASS_EN
    // Last broadcast value, shown while no completion is matching
    always_ff @(posedge clk) begin
        if (rst) begin
            udata_r <= '0;
        end else if (cap_s) begin
            udata_r <= rob.i_ALU_result;
        end
    end

    assign rob.o_ROB_u     = cap_s ? ({1'b0, hit_idx_s} + UNIT_W'(1)) : UNIT_W'(0);
    assign rob.o_ROB_udata = cap_s ? rob.i_ALU_result : udata_r;
`else
    logic [UNIT_W-1:0] bcast_u_r;

    // One-cycle registered broadcast following the capture edge
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_u_r <= '0;
            udata_r   <= '0;
        end else begin
            bcast_u_r <= cap_s ? ({1'b0, hit_idx_s} + UNIT_W'(1)) : UNIT_W'(0);
            if (cap_s) begin
                udata_r <= rob.i_ALU_result;
            end
        end
    end

    assign rob.o_ROB_u     = bcast_u_r;
    assign rob.o_ROB_udata = udata_r;
`endif

    assign rob.o_IDSUE_u     = unit_r;
    assign rob.o_IDSUE_full  = full_r;
    assign rob.o_REG_we      = reg_we_r;
    assign rob.o_REG_rd      = reg_rd_r;
    assign rob.o_REG_data    = reg_data_r;
    assign rob.o_PC_redirect = redirect_r;
    assign rob.o_PC_target   = target_r;
    assign rob.o_excp_valid  = excp_valid_r;
    assign rob.o_excp_code   = excp_code_r;
    assign rob.o_excp_pc     = excp_pc_r;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: per-cycle vector table plus directed full/wrap,
// redirect and exception sequences. Works with or without ROB_BYPASS_EN.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.PTR_W(3)) bus ();
    reorder_buffer #(.DEPTH(8), .PTR_W(3)) dut (.clk(clk), .rst(rst), .rob(bus));

    typedef struct {
        logic        alloc;
        logic [7:0]  cnt;
        logic [31:0] pc;
        logic [7:0]  acnt;
        logic [31:0] anewpc;
        logic [31:0] ares;
        logic [4:0]  ard;
        logic [3:0]  bu;    // broadcast unit caused by this row's ALU inputs
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic [3:0]  eu;    // o_IDSUE_u seen during this row
    } vec_t;

    vec_t vt[20];
    int   n_pass = 0;
    int   n_total = 0;

    int          we_n = 0, bc_n = 0, rd_n = 0, ex_n = 0;
    logic [4:0]  last_rd;
    logic [31:0] last_data, last_target, last_excp_pc, last_udata;
    logic [3:0]  last_u, last_code;

    function automatic vec_t mk(input logic al, input logic [7:0] c, input logic [31:0] p,
                                input logic [7:0] ac, input logic [31:0] anp, input logic [31:0] ar,
                                input logic [4:0] ard, input logic [3:0] bu, input logic ewe,
                                input logic [4:0] erd, input logic [31:0] ed, input logic [3:0] eu);
        vec_t v;
        v.alloc = al; v.cnt = c; v.pc = p; v.acnt = ac; v.anewpc = anp; v.ares = ar; v.ard = ard;
        v.bu = bu; v.ewe = ewe; v.erd = erd; v.edata = ed; v.eu = eu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic al, input logic [7:0] c, input logic [31:0] p,
                         input logic [7:0] ac, input logic [31:0] anp, input logic [31:0] ar,
                         input logic [4:0] ard, input logic [3:0] aex);
        bus.i_IDSUE_alloc = al; bus.i_IDSUE_cnt = c; bus.i_IDSUE_pc = p;
        bus.i_ALU_cnt = ac; bus.i_ALU_newpc = anp; bus.i_ALU_result = ar;
        bus.i_ALU_rd = ard; bus.i_ALU_excp = aex;
    endtask

    task automatic step(input logic al, input logic [7:0] c, input logic [31:0] p,
                        input logic [7:0] ac, input logic [31:0] anp, input logic [31:0] ar,
                        input logic [4:0] ard, input logic [3:0] aex);
        drive(al, c, p, ac, anp, ar, ard, aex);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'd0, 32'd0, 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
    endtask

    // Event recorder for strobes and broadcasts, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_REG_we) begin we_n++; last_rd = bus.o_REG_rd; last_data = bus.o_REG_data; end
        if (bus.o_PC_redirect) begin rd_n++; last_target = bus.o_PC_target; end
        if (bus.o_excp_valid) begin ex_n++; last_code = bus.o_excp_code; last_excp_pc = bus.o_excp_pc; end
        if (bus.o_ROB_u != 4'd0) begin bc_n++; last_u = bus.o_ROB_u; last_udata = bus.o_ROB_udata; end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int b_we, b_bc, b_rd, b_ex;
        logic [3:0]  exp_u;
        logic [31:0] exp_ud;

        vt[0]  = mk(1'b1, 8'd5, 32'h100, 8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd1);
        vt[1]  = mk(1'b0, 8'd0, 32'h0,   8'd5, 32'h104, 32'h2A, 5'd3, 4'd1, 1'b0, 5'd0, 32'h0,  4'd2);
        vt[2]  = mk(1'b0, 8'd0, 32'h0,   8'd5, 32'h104, 32'h2A, 5'd3, 4'd0, 1'b0, 5'd0, 32'h0,  4'd2);
        vt[3]  = mk(1'b0, 8'd0, 32'h0,   8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b1, 5'd3, 32'h2A, 4'd2);
        vt[4]  = mk(1'b1, 8'd1, 32'h110, 8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd2);
        vt[5]  = mk(1'b1, 8'd2, 32'h114, 8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd3);
        vt[6]  = mk(1'b1, 8'd3, 32'h118, 8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd4);
        vt[7]  = mk(1'b0, 8'd0, 32'h0,   8'd3, 32'h11C, 32'h33, 5'd7, 4'd4, 1'b0, 5'd0, 32'h0,  4'd5);
        vt[8]  = mk(1'b0, 8'd0, 32'h0,   8'd1, 32'h114, 32'h11, 5'd5, 4'd2, 1'b0, 5'd0, 32'h0,  4'd5);
        vt[9]  = mk(1'b0, 8'd0, 32'h0,   8'd2, 32'h118, 32'h22, 5'd6, 4'd3, 1'b0, 5'd0, 32'h0,  4'd5);
        vt[10] = mk(1'b0, 8'd0, 32'h0,   8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b1, 5'd5, 32'h11, 4'd5);
        vt[11] = mk(1'b0, 8'd0, 32'h0,   8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b1, 5'd6, 32'h22, 4'd5);
        vt[12] = mk(1'b0, 8'd0, 32'h0,   8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b1, 5'd7, 32'h33, 4'd5);
        vt[13] = mk(1'b1, 8'd7, 32'h140, 8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd5);
        vt[14] = mk(1'b0, 8'd0, 32'h0,   8'd7, 32'h144, 32'h77, 5'd9, 4'd5, 1'b0, 5'd0, 32'h0,  4'd6);
        vt[15] = mk(1'b0, 8'd0, 32'h0,   8'd7, 32'h144, 32'h77, 5'd9, 4'd0, 1'b0, 5'd0, 32'h0,  4'd6);
        vt[16] = mk(1'b0, 8'd0, 32'h0,   8'd7, 32'h144, 32'h77, 5'd9, 4'd0, 1'b1, 5'd9, 32'h77, 4'd6);
        vt[17] = mk(1'b0, 8'd0, 32'h0,   8'd7, 32'h144, 32'h77, 5'd9, 4'd0, 1'b0, 5'd0, 32'h0,  4'd6);
        vt[18] = mk(1'b0, 8'd0, 32'h0,   8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd6);
        vt[19] = mk(1'b0, 8'd0, 32'h0,   8'd0, 32'h0,   32'h0,  5'd0, 4'd0, 1'b0, 5'd0, 32'h0,  4'd6);

        // Reset state
        drive(1'b0, 8'd0, 32'd0, 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rob_u", 32'(bus.o_ROB_u), 32'd0);
        chk("rst_udata", bus.o_ROB_udata, 32'd0);
        chk("rst_we", 32'(bus.o_REG_we), 32'd0);
        chk("rst_reg_rd", 32'(bus.o_REG_rd), 32'd0);
        chk("rst_reg_data", bus.o_REG_data, 32'd0);
        chk("rst_redirect", 32'(bus.o_PC_redirect), 32'd0);
        chk("rst_target", bus.o_PC_target, 32'd0);
        chk("rst_excp_valid", 32'(bus.o_excp_valid), 32'd0);
        chk("rst_excp_code", 32'(bus.o_excp_code), 32'd0);
        chk("rst_excp_pc", bus.o_excp_pc, 32'd0);
        chk("rst_full", 32'(bus.o_IDSUE_full), 32'd0);
        chk("rst_idsue_u", 32'(bus.o_IDSUE_u), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Per-cycle vectors: single op, out-of-order completion, held ALU tag
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].alloc, vt[i].cnt, vt[i].pc, vt[i].acnt, vt[i].anewpc, vt[i].ares, vt[i].ard, 4'd0);
            @(negedge clk);
`ifdef ROB_BYPASS_EN
            exp_u  = vt[i].bu;
            exp_ud = vt[i].ares;
`else
            exp_u  = (i == 0) ? 4'd0 : vt[i-1].bu;
            exp_ud = (i == 0) ? 32'd0 : vt[i-1].ares;
`endif
            chk($sformatf("v%0d_rob_u", i), 32'(bus.o_ROB_u), 32'(exp_u));
            if (exp_u != 4'd0) chk($sformatf("v%0d_udata", i), bus.o_ROB_udata, exp_ud);
            chk($sformatf("v%0d_we", i), 32'(bus.o_REG_we), 32'(vt[i].ewe));
            if (vt[i].ewe) begin
                chk($sformatf("v%0d_reg_rd", i), 32'(bus.o_REG_rd), 32'(vt[i].erd));
                chk($sformatf("v%0d_reg_data", i), bus.o_REG_data, vt[i].edata);
            end
            chk($sformatf("v%0d_redirect", i), 32'(bus.o_PC_redirect), 32'd0);
            chk($sformatf("v%0d_excp", i), 32'(bus.o_excp_valid), 32'd0);
            chk($sformatf("v%0d_full", i), 32'(bus.o_IDSUE_full), 32'd0);
            chk($sformatf("v%0d_idsue_u", i), 32'(bus.o_IDSUE_u), 32'(vt[i].eu));
            @(posedge clk);
            #1;
        end

        // Fill to full, drop allocs while full (including on a commit edge), reuse slot 0 after wrap
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'(10 + k), 32'h400 + 32'(4 * k), 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
            if (k == 6) chk("fill7_full", 32'(bus.o_IDSUE_full), 32'd0);
        end
        chk("fill8_full", 32'(bus.o_IDSUE_full), 32'd1);
        chk("fill8_idsue_u", 32'(bus.o_IDSUE_u), 32'd1);
        b_we = we_n;
        step(1'b1, 8'd18, 32'h600, 8'd10, 32'h404, 32'hA0, 5'd1, 4'd0);
        chk("full_drop_full", 32'(bus.o_IDSUE_full), 32'd1);
        step(1'b1, 8'd20, 32'h604, 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        chk("commit_edge_full", 32'(bus.o_IDSUE_full), 32'd0);
        chk("commit_edge_u", 32'(bus.o_IDSUE_u), 32'd1);
        step(1'b1, 8'd19, 32'h500, 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        chk("refill_full", 32'(bus.o_IDSUE_full), 32'd1);
        chk("refill_u", 32'(bus.o_IDSUE_u), 32'd2);
        idle(1);
        chk("wrap_we_count", 32'(we_n - b_we), 32'd1);
        chk("wrap_we_rd", 32'(last_rd), 32'd1);
        chk("wrap_we_data", last_data, 32'hA0);
        b_bc = bc_n;
        step(1'b0, 8'd0, 32'd0, 8'd18, 32'h604, 32'hE1, 5'd2, 4'd0);
        step(1'b0, 8'd0, 32'd0, 8'd20, 32'h608, 32'hE2, 5'd2, 4'd0);
        step(1'b0, 8'd0, 32'd0, 8'd19, 32'h504, 32'hB9, 5'd2, 4'd0);
        idle(2);
        chk("wrap_bc_count", 32'(bc_n - b_bc), 32'd1);
        chk("wrap_bc_u", 32'(last_u), 32'd1);
        chk("wrap_bc_udata", last_udata, 32'hB9);

        // Mid-operation reset, then branch redirect with a younger entry in flight
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_full", 32'(bus.o_IDSUE_full), 32'd0);
        chk("midrst_u", 32'(bus.o_IDSUE_u), 32'd1);
        b_we = we_n; b_rd = rd_n; b_ex = ex_n;
        step(1'b1, 8'd30, 32'h200, 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        step(1'b1, 8'd31, 32'h204, 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        step(1'b0, 8'd0, 32'd0, 8'd30, 32'h180, 32'h55, 5'd0, 4'd0);
        idle(3);
        chk("br_we_count", 32'(we_n - b_we), 32'd0);
        chk("br_redirect_count", 32'(rd_n - b_rd), 32'd1);
        chk("br_target", last_target, 32'h180);
        chk("br_excp_count", 32'(ex_n - b_ex), 32'd0);
        chk("br_empty_u", 32'(bus.o_IDSUE_u), 32'd1);
        chk("br_empty_full", 32'(bus.o_IDSUE_full), 32'd0);
        b_bc = bc_n;
        step(1'b0, 8'd0, 32'd0, 8'd31, 32'h208, 32'h66, 5'd8, 4'd0);
        idle(3);
        chk("br_younger_bc", 32'(bc_n - b_bc), 32'd0);
        chk("br_younger_we", 32'(we_n - b_we), 32'd0);

        // Exception at retirement
        b_we = we_n; b_rd = rd_n; b_ex = ex_n;
        step(1'b1, 8'd40, 32'h300, 8'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        step(1'b0, 8'd0, 32'd0, 8'd40, 32'h304, 32'h99, 5'd4, 4'd2);
        idle(3);
        chk("ex_count", 32'(ex_n - b_ex), 32'd1);
        chk("ex_code", 32'(last_code), 32'd2);
        chk("ex_pc", last_excp_pc, 32'h300);
        chk("ex_we_count", 32'(we_n - b_we), 32'd0);
        chk("ex_redirect_count", 32'(rd_n - b_rd), 32'd0);
        chk("ex_flush_u", 32'(bus.o_IDSUE_u), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
